// File: rtl/traffic_pkg.sv
// Shared types and default timing for the four-phase intersection scheduler.
//   phase_t : the four signal phases, bit index of req/green/yellow/pending
//   stage_t : scheduler stage as presented on the stage output
//   DEF_*   : default interval lengths in clock cycles
package traffic_pkg;

  typedef enum logic [1:0] {
    NS_THRU = 2'd0,
    NS_LEFT = 2'd1,
    EW_THRU = 2'd2,
    EW_LEFT = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    ALL_RED = 2'd3
  } stage_t;

  localparam int unsigned DEF_MIN_GREEN = 10;
  localparam int unsigned DEF_MAX_GREEN = 40;
  localparam int unsigned DEF_GAP_EXT   = 3;
  localparam int unsigned DEF_YELLOW_T  = 5;
  localparam int unsigned DEF_ALL_RED_T = 2;

  function automatic logic [3:0] phase_onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/rr_phase_picker.sv
// Round-robin phase picker (combinational).
//   pending      : latched demand per phase
//   active_phase : phase currently or last served
//   next         : first pending phase searching active_phase+1, +2, +3, +0
//   valid        : some phase is pending
module rr_phase_picker
  import traffic_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [1:0] active_phase,
  output logic [1:0] next,
  output logic       valid
);

  always_comb begin
    next  = '0;
    valid = 1'b0;
    // Offset 4 wraps to the active phase itself, so it is considered last.
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!valid && pending[active_phase + 2'(i)]) begin
        next  = active_phase + 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// Four-phase signal scheduler: latches demand, serves phases round-robin,
// times green (min/max/gap-out), yellow and all-red, honours emergency preempt.
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   req[3:0]           : level demand per phase
//   preempt            : emergency preempt (level)
//   preempt_phase[1:0] : phase forced while preempt=1
//   green/yellow[3:0]  : one-hot registered lamps
//   stage[1:0]         : IDLE/GREEN/YELLOW/ALL_RED
//   active_phase[1:0]  : phase currently or last served
//   phase_start        : pulse on first green cycle of a phase
//   pending[3:0]       : latched demand not yet served
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
  parameter int unsigned GAP_EXT   = DEF_GAP_EXT,
  parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
  parameter int unsigned ALL_RED_T = DEF_ALL_RED_T
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_phase,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [1:0] stage,
  output logic [1:0] active_phase,
  output logic       phase_start,
  output logic [3:0] pending
);

  localparam int unsigned TW = $clog2(MAX_GREEN + 1);
  localparam int unsigned GW = $clog2(GAP_EXT + 1);

  // Terminal timer values: "k cycles in state" is timer == k-1.
  localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_YEL = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR  = TW'(ALL_RED_T - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_EXT);

  stage_t        stage_q, stage_d;
  logic [1:0]    phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    green_q, green_d;
  logic [3:0]    yellow_q, yellow_d;
  logic          start_q, start_d;

  logic [1:0]    pick_next;
  logic          pick_valid;
  logic [3:0]    act_mask;
  logic          other_pending;
  logic          enter_green;

  rr_phase_picker u_picker (
    .pending      (pending_q),
    .active_phase (phase_q),
    .next         (pick_next),
    .valid        (pick_valid)
  );

  always_comb begin
    stage_d       = stage_q;
    phase_d       = phase_q;
    act_mask      = phase_onehot(phase_q);
    other_pending = |(pending_q & ~act_mask);

    unique case (stage_q)
      IDLE: begin
        if (preempt) begin
          stage_d = GREEN;
          phase_d = preempt_phase;
        end else if (pick_valid) begin
          stage_d = GREEN;
          phase_d = pick_next;
        end
      end
      GREEN: begin
        if (preempt) begin
          if (preempt_phase != phase_q) stage_d = YELLOW;
        end else if (timer_q >= T_MIN && other_pending &&
                     (gap_q == '0 || timer_q >= T_MAX)) begin
          stage_d = YELLOW;
        end
      end
      YELLOW: begin
        if (timer_q == T_YEL) stage_d = ALL_RED;
      end
      ALL_RED: begin
        if (timer_q == T_AR) begin
          if (preempt) begin
            stage_d = GREEN;
            phase_d = preempt_phase;
          end else if (pick_valid) begin
            stage_d = GREEN;
            phase_d = pick_next;
          end else begin
            stage_d = IDLE;
          end
        end
      end
      default: stage_d = IDLE;
    endcase

    enter_green = (stage_d == GREEN) && (stage_q != GREEN);

    // Timer saturates so an indefinite green rest cannot wrap into a false MIN/MAX hit.
    if (stage_d != stage_q)  timer_d = '0;
    else if (timer_q == '1)  timer_d = timer_q;
    else                     timer_d = timer_q + TW'(1);

    // Gap only tracks the served detector during green; it restarts from zero each phase.
    if (stage_q == GREEN) begin
      if (req[phase_q])      gap_d = GAP_LOAD;
      else if (gap_q == '0)  gap_d = '0;
      else                   gap_d = gap_q - GW'(1);
    end else begin
      gap_d = '0;
    end

    pending_d = pending_q | (req & ~((stage_q == GREEN) ? act_mask : 4'b0000));
    if (enter_green) pending_d = pending_d & ~phase_onehot(phase_d);

    // Lamps are decoded from the next state so they register on the same edge.
    green_d  = (stage_d == GREEN)  ? phase_onehot(phase_d) : 4'b0000;
    yellow_d = (stage_d == YELLOW) ? phase_onehot(phase_d) : 4'b0000;
    start_d  = enter_green;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= IDLE;
      phase_q   <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      pending_q <= '0;
      green_q   <= '0;
      yellow_q  <= '0;
      start_q   <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      start_q   <= start_d;
    end
  end

  assign green        = green_q;
  assign yellow       = yellow_q;
  assign stage        = stage_q;
  assign active_phase = phase_q;
  assign phase_start  = start_q;
  assign pending      = pending_q;

endmodule
